ps2_move_receiver: RTL



---
 rtl/ps2_move_receiver_pkg.sv | 25 ++
 rtl/ps2_move_receiver_if.sv | 17 +
 rtl/ps2_move_receiver_clk_filter.sv | 43 ++++
 rtl/ps2_move_receiver.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ps2_move_receiver_pkg.sv
// Shared types and scan-code constants for the PS/2 move receiver.
package ps2_pkg;

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_ENTER = 8'h5A;

  localparam logic [7:0] DIGIT_TOP [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                           8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] DIGIT_PAD [9] = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73,
                                           8'h74, 8'h6C, 8'h75, 8'h7D};

  // One-hot box for a digit key from either the top row or the keypad; zero if unmapped.
  function automatic logic [8:0] digit_box(input logic [7:0] code);
    logic [8:0] box;
    box = '0;
    for (int i = 0; i < 9; i++) begin
      if (code == DIGIT_TOP[i] || code == DIGIT_PAD[i]) box[i] = 1'b1;
    end
    return box;
  endfunction

endpackage

// File: rtl/ps2_move_receiver_if.sv
// Keyboard-line inputs and decoded move outputs of the PS/2 move receiver.
interface ps2_move_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic [8:0] move_box;
  logic       move_valid;
  logic       confirm;
  logic       scan_ext;

  modport master (output ps2_clk, ps2_data,
                  input  scan_code, code_valid, frame_err, move_box, move_valid, confirm, scan_ext);
  modport slave  (input  ps2_clk, ps2_data,
                  output scan_code, code_valid, frame_err, move_box, move_valid, confirm, scan_ext);
endinterface

// File: rtl/ps2_move_receiver_clk_filter.sv
// Synchronizes the raw PS/2 clock, debounces it over FILTER_LEN samples and pulses on its falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // The level only flips once FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_fall  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync2;
        r_fall  <= r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_fall = r_fall;
endmodule

// File: rtl/ps2_move_receiver.sv
// PS/2 device->host frame receiver decoding digit keys into box moves and Enter into confirm.
// Optional build macro PS2_EXTENDED_EN: track E0 prefixes and keep extended keys out of the move path.
module ps2_move_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 reset,
  ps2_move_receiver_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t        r_state;
  logic          r_dataS1;
  logic          r_dataS2;
  logic [2:0]    r_bitCnt;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_breakPend;
  logic [7:0]    r_scanCode;
  logic          r_codeValid;
  logic          r_frameErr;
  logic [8:0]    r_moveBox;
  logic          r_moveValid;
  logic          r_confirm;
  logic          w_fall;
  logic [8:0]    w_box;
  logic          w_moveOk;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clkFilter (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (bus.ps2_clk),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataS1 <= 1'b1;
      r_dataS2 <= 1'b1;
    end else begin
      r_dataS1 <= bus.ps2_data;
      r_dataS2 <= r_dataS1;
    end
  end

  assign w_box = digit_box(r_shift);

`ifdef PS2_EXTENDED_EN
  logic r_extPend;
  logic r_scanExt;
  assign w_moveOk     = !r_breakPend && !r_extPend;
  assign bus.scan_ext = r_scanExt;
`else
  assign w_moveOk     = !r_breakPend;
  assign bus.scan_ext = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_timer     <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_breakPend <= 1'b0;
      r_scanCode  <= '0;
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
      r_moveBox   <= '0;
      r_moveValid <= 1'b0;
      r_confirm   <= 1'b0;
`ifdef PS2_EXTENDED_EN
      r_extPend   <= 1'b0;
      r_scanExt   <= 1'b0;
`endif
    end else begin
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
      r_moveValid <= 1'b0;
      r_confirm   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall && !r_dataS2) begin
            r_state  <= DATA;
            r_bitCnt <= '0;
            r_timer  <= '0;
          end
        end
        DATA, PARITY, STOP: begin
          if (w_fall) begin
            r_timer <= '0;
            case (r_state)
              DATA: begin
                r_shift  <= {r_dataS2, r_shift[7:1]};
                r_bitCnt <= r_bitCnt + 3'd1;
                if (r_bitCnt == 3'd7) r_state <= PARITY;
              end
              PARITY: begin
                r_parity <= r_dataS2;
                r_state  <= STOP;
              end
              default: begin
                if (r_dataS2 && (^{r_shift, r_parity})) begin
                  r_state <= DONE;
                end else begin
                  r_frameErr <= 1'b1;
                  r_state    <= IDLE;
                end
              end
            endcase
          end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_frameErr <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          // Prefix bytes only arm flags; the byte after them is the one reported.
          if (r_shift == PS2_BREAK) begin
            r_breakPend <= 1'b1;
          end else if (r_shift == PS2_EXT) begin
`ifdef PS2_EXTENDED_EN
            r_extPend <= 1'b1;
`endif
          end else begin
            r_codeValid <= 1'b1;
            r_scanCode  <= r_shift;
            r_breakPend <= 1'b0;
`ifdef PS2_EXTENDED_EN
            r_scanExt   <= r_extPend;
            r_extPend   <= 1'b0;
`endif
            if (w_moveOk) begin
              if (|w_box) begin
                r_moveValid <= 1'b1;
                r_moveBox   <= w_box;
              end
              r_confirm <= (r_shift == PS2_ENTER);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.scan_code  = r_scanCode;
  assign bus.code_valid = r_codeValid;
  assign bus.frame_err  = r_frameErr;
  assign bus.move_box   = r_moveBox;
  assign bus.move_valid = r_moveValid;
  assign bus.confirm    = r_confirm;
endmodule
